f_fetch_stage: RTL and testbench

- Fetch stage of the five-stage MIPS pipeline: the PC register, next-PC selection, and the F/D pipeline register.
- Consumes Bflag from the D-stage comparator, together with the D-stage control-transfer decode, and redirects fetch under delayed-branch semantics.
- Handles exception entry, eret return, hazard stalls, and AdEL detection on instruction fetch.
- Its F/D register feeds the D stage: decoder, comparator and hazard unit.

---
 rtl/f_fetch_stage_pkg.sv | 18 +
 rtl/f_fetch_stage_npc.sv | 45 ++++
 rtl/f_fetch_stage.sv | 97 +++++++++
 tb/tb_f_fetch_stage.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/f_fetch_stage_pkg.sv
// Shared definitions for the fetch stage and its neighbours.
// Holds the control-transfer class encodings carried on npc_op, the
// exception code raised on an illegal instruction fetch, and the
// reset/handler addresses that CP0 and the hazard unit also rely on.
package f_fetch_stage_pkg;

  localparam logic [2:0] NPC_PC4 = 3'd0;
  localparam logic [2:0] NPC_B   = 3'd1;
  localparam logic [2:0] NPC_J   = 3'd2;
  localparam logic [2:0] NPC_JR  = 3'd3;

  localparam logic [4:0] EXC_NONE = 5'd0;
  localparam logic [4:0] EXC_ADEL = 5'd4;

  localparam logic [31:0] PC_RESET_ADDR = 32'h0000_3000;
  localparam logic [31:0] HANDLER_ADDR  = 32'h0000_4180;

endpackage

// File: rtl/f_fetch_stage_npc.sv
// Next-PC selection for the fetch stage (purely combinational).
// Ports:
//   npc_op  - control-transfer class of the instruction in D
//   bflag   - comparator result for a branch in D
//   imm16   - branch offset field of the D instruction
//   index26 - j/jal index field of the D instruction
//   rs_val  - forwarded rs value for jr/jalr
//   d_pc    - PC of the instruction in D
//   f_pc    - PC currently being fetched
//   npc     - next fetch address
// Delayed-branch semantics: the fall-through address is f_pc+4 because
// the delay-slot instruction is already being fetched.
module f_fetch_stage_npc
  import f_fetch_stage_pkg::*;
(
  input  logic [2:0]  npc_op,
  input  logic        bflag,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_val,
  input  logic [31:0] d_pc,
  input  logic [31:0] f_pc,
  output logic [31:0] npc
);

  logic signed [31:0] br_off;
  logic        [31:0] seq_pc;
  logic        [31:0] br_pc;

  // Word offset: sign-extend then scale by 4; adds wrap modulo 2^32.
  assign br_off = {{14{imm16[15]}}, imm16, 2'b00};
  assign seq_pc = f_pc + 32'd4;
  assign br_pc  = d_pc + 32'd4 + $unsigned(br_off);

  always_comb begin
    npc = seq_pc;
    case (npc_op)
      NPC_B:   npc = bflag ? br_pc : seq_pc;
      NPC_J:   npc = {d_pc[31:28], index26, 2'b00};
      NPC_JR:  npc = rs_val;
      default: npc = seq_pc;
    endcase
  end

endmodule

// File: rtl/f_fetch_stage.sv
// Fetch stage of the five-stage MIPS pipeline: PC register, next-PC
// selection and the F/D pipeline register, including exception entry,
// eret return, hazard stalls and AdEL detection on instruction fetch.
// Ports:
//   clk, reset      - clock; synchronous active-high reset
//   stall           - hazard-unit stall of F and D
//   req             - CP0 exception/interrupt request (go to HANDLER)
//   eret_D, epc     - eret decoded in D and the return address
//   npc_op, Bflag   - D-stage control-transfer class and branch outcome
//   imm16, index26  - D instruction offset/index fields
//   rs_val          - forwarded rs for jr/jalr
//   i_inst_rdata    - instruction memory data for i_inst_addr
//   i_inst_addr     - fetch address (same as F_pc)
//   F_pc            - PC register
//   D_instr, D_pc, D_exc, D_bd - F/D register contents
module f_fetch_stage
  import f_fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_ADDR,
  parameter logic [31:0] HANDLER  = HANDLER_ADDR,
  parameter logic [31:0] IM_LO    = 32'h0000_3000,
  parameter logic [31:0] IM_HI    = 32'h0000_6ffc
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        req,
  input  logic        eret_D,
  input  logic [31:0] epc,
  input  logic [2:0]  npc_op,
  input  logic        Bflag,
  input  logic [15:0] imm16,
  input  logic [25:0] index26,
  input  logic [31:0] rs_val,
  input  logic [31:0] i_inst_rdata,
  output logic [31:0] i_inst_addr,
  output logic [31:0] F_pc,
  output logic [31:0] D_instr,
  output logic [31:0] D_pc,
  output logic [4:0]  D_exc,
  output logic        D_bd
);

  logic [31:0] npc;
  logic        fetch_bad;

  // Misaligned or outside the instruction memory window; both bounds legal.
  function automatic logic fetch_illegal(input logic [31:0] pc);
    return (pc[1:0] != 2'b00) || (pc < IM_LO) || (pc > IM_HI);
  endfunction

  f_fetch_stage_npc u_npc (
    .npc_op  (npc_op),
    .bflag   (Bflag),
    .imm16   (imm16),
    .index26 (index26),
    .rs_val  (rs_val),
    .d_pc    (D_pc),
    .f_pc    (F_pc),
    .npc     (npc)
  );

  assign fetch_bad   = fetch_illegal(F_pc);
  assign i_inst_addr = F_pc;

  // F -> D boundary. Priority: reset > req > eret (unstalled) > stall > advance.
  // A stalled eret simply holds until the hazard unit releases it with a
  // valid epc; the unstalled eret flushes its would-be slot to a nop.
  always_ff @(posedge clk) begin
    if (reset) begin
      F_pc    <= PC_RESET;
      D_instr <= 32'd0;
      D_pc    <= PC_RESET;
      D_exc   <= EXC_NONE;
      D_bd    <= 1'b0;
    end else if (req) begin
      F_pc    <= HANDLER;
      D_instr <= 32'd0;
      D_pc    <= HANDLER;
      D_exc   <= EXC_NONE;
      D_bd    <= 1'b0;
    end else if (eret_D && !stall) begin
      F_pc    <= epc;
      D_instr <= 32'd0;
      D_pc    <= epc;
      D_exc   <= EXC_NONE;
      D_bd    <= 1'b0;
    end else if (!stall) begin
      F_pc    <= npc;
      D_pc    <= F_pc;
      D_bd    <= (npc_op != NPC_PC4);
      D_instr <= fetch_bad ? 32'd0 : i_inst_rdata;
      D_exc   <= fetch_bad ? EXC_ADEL : EXC_NONE;
    end
  end

endmodule

// File: tb/tb_f_fetch_stage.sv
module tb_f_fetch_stage;

  logic        clk = 1'b0;
  logic        reset, stall, req, eret_D, Bflag;
  logic [31:0] epc, rs_val, i_inst_rdata;
  logic [2:0]  npc_op;
  logic [15:0] imm16;
  logic [25:0] index26;
  logic [31:0] i_inst_addr, F_pc, D_instr, D_pc;
  logic [4:0]  D_exc;
  logic        D_bd;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state
  logic [31:0] m_fpc, m_dinstr, m_dpc;
  logic [4:0]  m_dexc;
  logic        m_dbd;

  always #5 clk = ~clk;

  f_fetch_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .req(req), .eret_D(eret_D),
    .epc(epc), .npc_op(npc_op), .Bflag(Bflag), .imm16(imm16),
    .index26(index26), .rs_val(rs_val), .i_inst_rdata(i_inst_rdata),
    .i_inst_addr(i_inst_addr), .F_pc(F_pc), .D_instr(D_instr), .D_pc(D_pc),
    .D_exc(D_exc), .D_bd(D_bd)
  );

  // Instruction memory image: a distinct nonzero word per address.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0001;
  endfunction

  assign i_inst_rdata = mem_word(i_inst_addr);

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  // Spec-level next-PC: plain integer arithmetic on addresses.
  function automatic logic [31:0] ref_npc();
    longint off;
    off = 4 * longint'($signed(imm16));
    case (npc_op)
      3'd1:    return Bflag ? 32'(longint'(m_dpc) + 4 + off) : m_fpc + 4;
      3'd2:    return (m_dpc & 32'hF000_0000) | (32'(index26) * 4);
      3'd3:    return rs_val;
      default: return m_fpc + 4;
    endcase
  endfunction

  function automatic bit ref_legal(input logic [31:0] a);
    return (a % 4 == 0) && (a >= 32'h3000) && (a <= 32'h6ffc);
  endfunction

  // Apply one clock with the currently driven inputs, advance the model, compare.
  task automatic step();
    logic [31:0] nf, ni, np;
    logic [4:0]  ne;
    logic        nb;
    nf = m_fpc; ni = m_dinstr; np = m_dpc; ne = m_dexc; nb = m_dbd;
    if (reset) begin
      nf = 32'h3000; ni = 0; np = 32'h3000; ne = 0; nb = 0;
    end else if (req) begin
      nf = 32'h4180; ni = 0; np = 32'h4180; ne = 0; nb = 0;
    end else if (eret_D && !stall) begin
      nf = epc; ni = 0; np = epc; ne = 0; nb = 0;
    end else if (!stall) begin
      nf = ref_npc();
      np = m_fpc;
      nb = (npc_op != 3'd0);
      if (ref_legal(m_fpc)) begin ni = mem_word(m_fpc); ne = 0; end
      else begin ni = 0; ne = 4; end
    end
    @(posedge clk);
    #1;
    m_fpc = nf; m_dinstr = ni; m_dpc = np; m_dexc = ne; m_dbd = nb;
    check("F_pc", F_pc, m_fpc);
    check("i_inst_addr", i_inst_addr, m_fpc);
    check("D_instr", D_instr, m_dinstr);
    check("D_pc", D_pc, m_dpc);
    check("D_exc", 32'(D_exc), 32'(m_dexc));
    check("D_bd", 32'(D_bd), 32'(m_dbd));
  endtask

  task automatic idle_inputs();
    reset = 0; stall = 0; req = 0; eret_D = 0; Bflag = 0;
    epc = 0; rs_val = 0; npc_op = 3'd0; imm16 = 0; index26 = 0;
  endtask

  initial begin
    m_fpc = 0; m_dinstr = 0; m_dpc = 0; m_dexc = 0; m_dbd = 0;
    idle_inputs();
    @(negedge clk);

    // Reset state
    reset = 1; step(); step();
    check("rst_F_pc", F_pc, 32'h3000);
    check("rst_D_pc", D_pc, 32'h3000);
    check("rst_D_instr", D_instr, 32'h0);
    reset = 0;

    // Free run
    step(); check("run1_F_pc", F_pc, 32'h3004); check("run1_D_pc", D_pc, 32'h3000);
    step(); check("run2_F_pc", F_pc, 32'h3008); check("run2_D_bd", 32'(D_bd), 32'h0);
    step(); step(); step();  // F_pc=0x3014, D_pc=0x3010
    check("pre_br_D_pc", D_pc, 32'h3010);

    // Taken backward branch
    npc_op = 3'd1; Bflag = 1; imm16 = 16'hFFFC; step();
    check("br_taken_F_pc", F_pc, 32'h3004);
    check("br_slot_D_pc", D_pc, 32'h3014);
    check("br_slot_D_bd", 32'(D_bd), 32'h1);
    check("br_slot_D_instr", D_instr, mem_word(32'h3014));

    // Re-align: reset, walk to D_pc=0x3010, then untaken branch
    idle_inputs(); reset = 1; step(); reset = 0;
    repeat (5) step();
    npc_op = 3'd1; Bflag = 0; imm16 = 16'hFFFC; step();
    check("br_nt_F_pc", F_pc, 32'h3018);
    idle_inputs();

    // Stall at 0x3020
    repeat (2) step();
    check("pre_stall_F_pc", F_pc, 32'h3020);
    stall = 1; step(); step();
    check("stall_F_pc", F_pc, 32'h3020);
    req = 1; step();
    check("req_F_pc", F_pc, 32'h4180);
    check("req_D_pc", D_pc, 32'h4180);
    idle_inputs();

    // eret: held while stalled, taken when released
    eret_D = 1; epc = 32'h3044; stall = 1; step();
    check("eret_stall_F_pc", F_pc, 32'h4180);
    stall = 0; step();
    check("eret_F_pc", F_pc, 32'h3044);
    check("eret_D_instr", D_instr, 32'h0);
    idle_inputs(); step();
    check("post_eret_D_instr", D_instr, mem_word(32'h3044));

    // jr to misaligned, then to out-of-range
    npc_op = 3'd3; rs_val = 32'h3002; step();
    check("jr_F_pc", F_pc, 32'h3002);
    idle_inputs(); step();
    check("adel_align_exc", 32'(D_exc), 32'h4);
    check("adel_align_instr", D_instr, 32'h0);
    npc_op = 3'd3; rs_val = 32'h7000; step();
    idle_inputs(); step();
    check("adel_range_exc", 32'(D_exc), 32'h4);
    check("adel_range_D_pc", D_pc, 32'h7000);

    // Bounds are legal
    npc_op = 3'd3; rs_val = 32'h6ffc; step();
    idle_inputs(); step();
    check("hi_bound_exc", 32'(D_exc), 32'h0);

    // Reset beats req and eret
    reset = 1; req = 1; eret_D = 1; epc = 32'h5000; step();
    check("rst_prio_F_pc", F_pc, 32'h3000);
    idle_inputs();

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      reset  = ($urandom_range(99) < 2);
      req    = ($urandom_range(99) < 3);
      eret_D = ($urandom_range(99) < 6);
      stall  = ($urandom_range(99) < 20);
      epc    = ($urandom_range(3) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(4095);
      npc_op = 3'($urandom_range(7));
      Bflag  = 1'($urandom_range(1));
      imm16  = 16'($urandom);
      index26 = ($urandom_range(1) == 0) ? 26'(32'h3000 / 4 + $urandom_range(4095)) : 26'($urandom);
      rs_val = ($urandom_range(4) == 0) ? $urandom : 32'h3000 + 4 * $urandom_range(4095);
      step();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
